// File: rtl/minterm_sweep_ctrl_if.sv
// Bundle between the lab top level (master) and the sweep sequencer (slave).
// Carries the run/abort handshake, the sweep results and the link to the
// 4-input function unit under test.
interface minterm_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [15:0] obs_mask;
  logic [3:0]  abcd;
  logic        f_in;

  modport master (
    output start, abort, f_in,
    input  busy, done, pass, err_count, first_fail, obs_mask, abcd
  );

  modport slave (
    input  start, abort, f_in,
    output busy, done, pass, err_count, first_fail, obs_mask, abcd
  );
endinterface

// File: rtl/minterm_sweep_ctrl.sv
// Minterm sweep sequencer: steps a 4-input function unit through all 16
// input vectors, waits SETTLE cycles per vector, samples f_in, and compares
// the observed truth table against EXP_MASK.
// Optional macro MINTERM_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first
// mismatching minterm instead of sweeping all 16.
module minterm_sweep_ctrl #(
  parameter logic [15:0] EXP_MASK = 16'h0727,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  minterm_sweep_ctrl_if.slave sw
);

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ERR_W     = 5;
  localparam int unsigned MASK_W    = 16;
  localparam int unsigned N_MINTERM = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    abcd_q, abcd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [IDX_W-1:0]    ff_q, ff_d;
  logic [MASK_W-1:0]   obs_q, obs_d;
  logic                mismatch_c;
  logic                fin_c;

  // Current sample disagrees with the expected truth table bit.
  assign mismatch_c = (sw.f_in != EXP_MASK[index_q]);

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      obs_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      obs_q   <= obs_d;
    end
  end

  // Next-state and result update; abort outranks every other transition.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    obs_d   = obs_q;
    fin_c   = 1'b0;

    if (sw.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sw.start && !sw.abort) begin
            state_d = S_DRIVE;
            index_d = '0;
            err_d   = '0;
            ff_d    = '0;
            obs_d   = '0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_DRIVE: begin
          abcd_d  = index_q;
          cnt_d   = CNT_W'(SETTLE);
          state_d = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
        end
        S_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          obs_d[index_q] = sw.f_in;
          if (mismatch_c) begin
            err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              ff_d = index_q;
            end
          end
`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
          fin_c = mismatch_c || (index_q == IDX_W'(N_MINTERM - 1));
`else
          fin_c = (index_q == IDX_W'(N_MINTERM - 1));
`endif
          if (fin_c) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == '0);
          end else begin
            index_d = index_q + IDX_W'(1);
            state_d = S_DRIVE;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign sw.abcd       = abcd_q;
  assign sw.busy       = busy_q;
  assign sw.done       = done_q;
  assign sw.pass       = pass_q;
  assign sw.err_count  = err_q;
  assign sw.first_fail = ff_q;
  assign sw.obs_mask   = obs_q;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Bench for minterm_sweep_ctrl: two instances (SETTLE=0 and SETTLE=1), each
// driving a modelled function unit given as a 16-bit truth table.
module tb_minterm_sweep_ctrl;

  localparam logic [15:0] EXP = 16'h0727;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  minterm_sweep_ctrl_if if0 ();
  minterm_sweep_ctrl_if if1 ();

  logic [15:0] fm0, fm1;
  logic [1:0]  start_v, abort_v;

  assign if0.f_in  = fm0[if0.abcd];
  assign if1.f_in  = fm1[if1.abcd];
  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if0.abort = abort_v[0];
  assign if1.abort = abort_v[1];

  minterm_sweep_ctrl #(.EXP_MASK(EXP), .SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .sw(if0));
  minterm_sweep_ctrl #(.EXP_MASK(EXP), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .sw(if1));

  logic [1:0]  busy_w, done_w, pass_w;
  logic [4:0]  err_w  [2];
  logic [3:0]  ff_w   [2];
  logic [3:0]  abcd_w [2];
  logic [15:0] obs_w  [2];

  assign busy_w    = {if1.busy, if0.busy};
  assign done_w    = {if1.done, if0.done};
  assign pass_w    = {if1.pass, if0.pass};
  assign err_w[0]  = if0.err_count;
  assign err_w[1]  = if1.err_count;
  assign ff_w[0]   = if0.first_fail;
  assign ff_w[1]   = if1.first_fail;
  assign abcd_w[0] = if0.abcd;
  assign abcd_w[1] = if1.abcd;
  assign obs_w[0]  = if0.obs_mask;
  assign obs_w[1]  = if1.obs_mask;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          sel;
    logic [15:0] f;
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic [15:0] obs;
    int          lat;
    logic [3:0]  last;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: walk the minterms in order, return what a sweep must report.
  task automatic ref_sweep(input logic [15:0] f, input int settle, output vec_t r);
    r.f = f; r.obs = '0; r.err = '0; r.ff = '0; r.last = 4'hF;
    r.lat = 16 * (2 + settle);
    for (int i = 0; i < 16; i++) begin
      r.obs[i] = f[i];
      if (f[i] != EXP[i]) begin
        if (r.err == 0) r.ff = 4'(i);
        r.err = r.err + 5'd1;
`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
        r.lat  = (i + 1) * (2 + settle);
        r.last = 4'(i);
        break;
`endif
      end
    end
    r.pass = (r.err == 0);
  endtask

  // One full sweep with latency/busy/done accounting and final result checks.
  task automatic run_sweep(input vec_t v, input bit restrike, input string tag);
    int lat, busy_cnt, done_cnt, s;
    s = v.sel;
    if (s == 0) fm0 = v.f; else fm1 = v.f;
    @(negedge clk); start_v[s] = 1'b1;
    @(posedge clk); #1;
    check($sformatf("%s busy_at_start", tag), 32'(busy_w[s]), 32'd1);
    check($sformatf("%s err_cleared", tag), 32'(err_w[s]), 32'd0);
    check($sformatf("%s obs_cleared", tag), 32'(obs_w[s]), 32'd0);
    @(negedge clk); start_v[s] = 1'b0;
    lat = -1; busy_cnt = 1; done_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) check($sformatf("%s first_vec", tag), 32'(abcd_w[s]), 32'd0);
      if (done_w[s]) begin
        if (lat < 0) lat = k;
        done_cnt++;
      end
      if (busy_w[s]) busy_cnt++;
      start_v[s] = restrike && (k >= 4) && (k <= 6);
      if ((lat >= 0) && (k >= lat + 3)) break;
    end
    start_v[s] = 1'b0;
    check($sformatf("%s latency", tag), 32'(lat), 32'(v.lat));
    check($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'(v.lat));
    check($sformatf("%s done_pulses", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s pass", tag), 32'(pass_w[s]), 32'(v.pass));
    check($sformatf("%s err_count", tag), 32'(err_w[s]), 32'(v.err));
    check($sformatf("%s first_fail", tag), 32'(ff_w[s]), 32'(v.ff));
    check($sformatf("%s obs_mask", tag), 32'(obs_w[s]), 32'(v.obs));
    check($sformatf("%s abcd_final", tag), 32'(abcd_w[s]), 32'(v.last));
  endtask

  initial begin
    vec_t r;
    bit   hit;
    int   dcnt, e_err;
    logic [15:0] e_obs, af;

`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
    tbl[0] = '{1, 16'h0727, 1'b1, 5'd0,  4'd0, 16'h0727, 48, 4'hF};
    tbl[1] = '{1, 16'h0000, 1'b0, 5'd1,  4'd0, 16'h0000,  3, 4'h0};
    tbl[2] = '{1, 16'h0707, 1'b0, 5'd1,  4'd5, 16'h0007, 18, 4'h5};
    tbl[3] = '{0, 16'h0727, 1'b1, 5'd0,  4'd0, 16'h0727, 32, 4'hF};
    tbl[4] = '{1, 16'hFFFF, 1'b0, 5'd1,  4'd3, 16'h000F, 12, 4'h3};
    tbl[5] = '{1, 16'hF8D8, 1'b0, 5'd1,  4'd0, 16'h0000,  3, 4'h0};
    tbl[6] = '{0, 16'h0707, 1'b0, 5'd1,  4'd5, 16'h0007, 12, 4'h5};
`else
    tbl[0] = '{1, 16'h0727, 1'b1, 5'd0,  4'd0, 16'h0727, 48, 4'hF};
    tbl[1] = '{1, 16'h0000, 1'b0, 5'd7,  4'd0, 16'h0000, 48, 4'hF};
    tbl[2] = '{1, 16'h0707, 1'b0, 5'd1,  4'd5, 16'h0707, 48, 4'hF};
    tbl[3] = '{0, 16'h0727, 1'b1, 5'd0,  4'd0, 16'h0727, 32, 4'hF};
    tbl[4] = '{1, 16'hFFFF, 1'b0, 5'd9,  4'd3, 16'hFFFF, 48, 4'hF};
    tbl[5] = '{1, 16'hF8D8, 1'b0, 5'd16, 4'd0, 16'hF8D8, 48, 4'hF};
    tbl[6] = '{0, 16'h0707, 1'b0, 5'd1,  4'd5, 16'h0707, 32, 4'hF};
`endif

    // Reset state
    rst_n = 1'b0; start_v = '0; abort_v = '0; fm0 = EXP; fm1 = EXP;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d busy", s), 32'(busy_w[s]), 32'd0);
      check($sformatf("rst%0d done", s), 32'(done_w[s]), 32'd0);
      check($sformatf("rst%0d pass", s), 32'(pass_w[s]), 32'd0);
      check($sformatf("rst%0d abcd", s), 32'(abcd_w[s]), 32'd0);
      check($sformatf("rst%0d obs", s), 32'(obs_w[s]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) run_sweep(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // start held 3 cycles mid-sweep must not launch a second sweep
    run_sweep(tbl[0], 1'b1, "restrike");

    // SETTLE=0: abcd walks 0..15, two cycles per vector
    fm0 = EXP;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start_v[0] = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      check($sformatf("step k=%0d abcd", k), 32'(abcd_w[0]), 32'((k - 1) / 2));
    end
    repeat (3) @(negedge clk);

    // Abort while abcd==6: partial results kept, no done, pass low
`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
    af = EXP;
`else
    af = 16'h0000;
`endif
    e_obs = '0; e_err = 0;
    for (int i = 0; i < 6; i++) begin
      e_obs[i] = af[i];
      if (af[i] != EXP[i]) e_err++;
    end
    fm1 = af;
    @(negedge clk); start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (abcd_w[1] == 4'd6) begin hit = 1'b1; break; end
    end
    check("abort reach_abcd6", 32'(hit), 32'd1);
    @(negedge clk); abort_v[1] = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 32'(busy_w[1]), 32'd0);
    check("abort done", 32'(done_w[1]), 32'd0);
    check("abort pass", 32'(pass_w[1]), 32'd0);
    check("abort err_kept", 32'(err_w[1]), 32'(e_err));
    check("abort obs_kept", 32'(obs_w[1]), 32'(e_obs));
    @(negedge clk); abort_v[1] = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done_w[1] || busy_w[1]) dcnt++;
    end
    check("abort stays_idle", 32'(dcnt), 32'd0);
    run_sweep(tbl[0], 1'b0, "after_abort");

    // start and abort together in IDLE: abort wins
    @(negedge clk); start_v[1] = 1'b1; abort_v[1] = 1'b1;
    @(posedge clk); #1;
    check("start_abort busy", 32'(busy_w[1]), 32'd0);
    @(negedge clk); start_v[1] = 1'b0; abort_v[1] = 1'b0;
    @(posedge clk); #1;
    check("start_abort busy_later", 32'(busy_w[1]), 32'd0);

    // Randomized truth tables against the reference model
    for (int n = 0; n < 16; n++) begin
      logic [15:0] f;
      int sel;
      sel = int'($urandom_range(0, 1));
      f = 16'($urandom);
      if ($urandom_range(0, 1) == 1) f = EXP ^ (16'h0001 << $urandom_range(0, 15));
      ref_sweep(f, sel, r);
      r.sel = sel;
      run_sweep(r, 1'b0, $sformatf("rnd%0d f=%h", n, f));
    end

    // Asynchronous reset mid-sweep at minterm 9
    fm1 = EXP;
    @(negedge clk); start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (abcd_w[1] == 4'd9) begin hit = 1'b1; break; end
    end
    check("midrst reach_abcd9", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy_w[1]), 32'd0);
    check("midrst done", 32'(done_w[1]), 32'd0);
    check("midrst pass", 32'(pass_w[1]), 32'd0);
    check("midrst err", 32'(err_w[1]), 32'd0);
    check("midrst ff", 32'(ff_w[1]), 32'd0);
    check("midrst obs", 32'(obs_w[1]), 32'd0);
    check("midrst abcd", 32'(abcd_w[1]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done_w[1] || busy_w[1]) dcnt++;
    end
    check("midrst no_resume", 32'(dcnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
